// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, one bit per Clk cycle.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Tx_out is a register loaded from the next state, so the start bit appears
// in the cycle after the accepting edge.
// Optional macro UART_TX_HOLD_BUF_EN adds a one-entry holding buffer so a
// second word can be queued during a frame and sent back-to-back.
//
// state  | meaning
// IDLE   | line high, waiting for a transfer
// START  | start bit (0) on the line
// DATA   | data bit cnt_q on the line, LSB first
// PARITY | parity of the latched word on the line
// STOP   | stop bit (1) on the line
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  Data_Valid,
    input  logic                  Parity_En,
    input  logic                  Parity_Typ,
    output logic                  Tx_out,
    output logic                  Busy,
    output logic                  Ready
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    pen_q, pen_d;
    logic                    ptyp_q, ptyp_d;
    logic                    tx_q, tx_d;
    logic                    xfer;

`ifdef UART_TX_HOLD_BUF_EN
    logic                    buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic                    buf_pen_q, buf_pen_d;
    logic                    buf_ptyp_q, buf_ptyp_d;

    assign Ready = ~buf_full_q;
    assign Busy  = (state_q != S_IDLE) | buf_full_q;
`else
    assign Ready = (state_q == S_IDLE);
    assign Busy  = (state_q != S_IDLE);
`endif

    assign xfer   = Data_Valid & Ready;
    assign Tx_out = tx_q;

    // Next-state, word latching, holding buffer and next line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pen_d   = pen_q;
        ptyp_d  = ptyp_q;
`ifdef UART_TX_HOLD_BUF_EN
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        buf_pen_d  = buf_pen_q;
        buf_ptyp_d = buf_ptyp_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef UART_TX_HOLD_BUF_EN
                // A word queued on the final stop cycle is launched first.
                if (buf_full_q) begin
                    data_d     = buf_data_q;
                    pen_d      = buf_pen_q;
                    ptyp_d     = buf_ptyp_q;
                    buf_full_d = 1'b0;
                    state_d    = S_START;
                end else
`endif
                if (xfer) begin
                    data_d  = P_Data;
                    pen_d   = Parity_En;
                    ptyp_d  = Parity_Typ;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = pen_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
`ifdef UART_TX_HOLD_BUF_EN
                if (buf_full_q) begin
                    data_d     = buf_data_q;
                    pen_d      = buf_pen_q;
                    ptyp_d     = buf_ptyp_q;
                    buf_full_d = 1'b0;
                    state_d    = S_START;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef UART_TX_HOLD_BUF_EN
        // Words accepted while a frame is running wait in the buffer.
        if (xfer && (state_q != S_IDLE)) begin
            buf_full_d = 1'b1;
            buf_data_d = P_Data;
            buf_pen_d  = Parity_En;
            buf_ptyp_d = Parity_Typ;
        end
`endif
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[cnt_d];
            S_PARITY: tx_d = (^data_d) ^ ptyp_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    // State, latched word and registered line output.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            pen_q   <= 1'b0;
            ptyp_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pen_q   <= pen_d;
            ptyp_q  <= ptyp_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TX_HOLD_BUF_EN
    // One-entry holding buffer.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            buf_pen_q  <= 1'b0;
            buf_ptyp_q <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            buf_pen_q  <= buf_pen_d;
            buf_ptyp_q <= buf_ptyp_d;
        end
    end
`endif

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the parallel data word.
REQ-002 Clk  input  1  transmit bit clock; one serial bit per Clk cycle; all state changes on the rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-low.
REQ-004 P_Data  input  DATA_WIDTH  parallel word to transmit.
REQ-005 Data_Valid  input  1  P_Data is valid this cycle; a transfer occurs when Data_Valid=1 and Ready=1 at a rising edge.
REQ-006 Parity_En  input  1  1 = a parity bit is inserted after the data bits.
REQ-007 Parity_Typ  input  1  0 = even parity (bit = XOR of data); 1 = odd parity (bit = XNOR of data).
REQ-008 Tx_out  output  1  serial line; idle level 1.
REQ-009 Busy  output  1  a frame is on the line or queued.
REQ-010 Ready  output  1  block can accept a word this cycle.

Function
REQ-011 FSM states: IDLE, START, DATA, PARITY, STOP; Tx_out is registered and driven from the current state.
REQ-012 IDLE: Tx_out=1, Busy=0; on a transfer, latch P_Data, Parity_En and Parity_Typ, and move to START.
REQ-013 START: Tx_out=0 for exactly one cycle, then move to DATA.
REQ-014 DATA: transmit DATA_WIDTH bits, LSB first, one per cycle; a bit counter runs 0..DATA_WIDTH-1; after the last bit, move to PARITY if the latched Parity_En=1, otherwise to STOP.
REQ-015 PARITY: Tx_out = parity of the latched word per the latched Parity_Typ, for one cycle, then move to STOP.
REQ-016 STOP: Tx_out=1 for one cycle, then move to IDLE, or to START under REQ-024.
REQ-017 Latency: the start bit appears on Tx_out in the cycle after the accepting edge.
REQ-018 Frame length is 2+DATA_WIDTH+Parity_En cycles: 11 with parity and 10 without, for DATA_WIDTH=8.
REQ-019 Busy=1 in START, DATA, PARITY and STOP.
REQ-020 Changes to P_Data, Parity_En or Parity_Typ during a frame do not affect the frame in flight.
REQ-021 Data_Valid=1 while Ready=0: the word is ignored (no error, no state change).
REQ-022 The parity bit is computed from the latched word, never from the live P_Data.

Reset
REQ-023 Rst=0 asynchronously forces IDLE, Tx_out=1, Busy=0, Ready=1, bit counter 0, and clears the holding buffer; a frame in progress is abandoned, and the line returns high immediately.

Configuration
REQ-024 The macro UART_TX_HOLD_BUF_EN compiles in a one-entry holding buffer:
- defined: Ready = NOT buffer_full; a transfer during a frame stores the word and its config into the buffer.
- defined, next frame: on leaving STOP with the buffer full, go directly to START with the buffered word (no idle cycle) and free the buffer.
- defined, Busy: Busy stays 1 while the buffer is full.
- defined, simultaneous events: a transfer in the same cycle as STOP exit with the buffer empty is also accepted and queued.
- not defined: no buffer; Ready = NOT Busy; at least one IDLE cycle separates frames.

Verification
REQ-025 Reset, then P_Data=0xBB, Parity_En=1, Parity_Typ=0, one-cycle Data_Valid -> Tx_out sequence 0,1,1,0,1,1,1,0,1,0,1 over 11 cycles, then idle 1.
REQ-026 Same as REQ-025 with Parity_Typ=1 -> parity bit 1; with Parity_En=0 -> 10-cycle frame 0,1,1,0,1,1,1,0,1,1; a looped-back uart_rx reports P_Data=0xBB with no parity or framing error in all three cases.
REQ-027 Without macro: Data_Valid with 0x55 held high during a 0xBB frame -> 0x55 is ignored; Ready=0 throughout the frame.
REQ-028 With macro: 0xBB then 0x3C offered mid-frame -> two contiguous frames with no idle cycle; a third word offered while the buffer is full is dropped.
REQ-029 Rst pulled low during DATA bit 4 -> Tx_out=1, Busy=0 immediately; the next transfer produces a clean full frame.
REQ-030 Parity_Typ toggled mid-frame -> the parity bit matches the value latched at acceptance.
